// File: rtl/mul_dispatch_pkg.sv
// Shared ALU definitions for the multiplier dispatch stage.
// State encoding, operand widths and result flag helpers.
package mul_dispatch_pkg;

  localparam int MUL_W  = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESULT
  } mul_disp_state_t;

  // True when the product cannot be represented as signed 8-bit.
  function automatic logic ovf8(input logic [PROD_W-1:0] p);
    return !((&p[PROD_W-1:MUL_W-1]) || !(|p[PROD_W-1:MUL_W-1]));
  endfunction

endpackage

// File: rtl/mul_operand_fifo.sv
// Small operand-pair FIFO feeding the multiplier dispatch FSM.
// Read data is the current head; pop advances it.
module mul_operand_fifo
  import mul_dispatch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 2 * MUL_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mul_dispatch.sv
// Issue stage for the sequential Booth multiplier: queue, start/done
// handshake with timeout, and a flagged result on valid/ready.
module mul_dispatch
  import mul_dispatch_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MUL_W-1:0]  in_a,
  input  logic [MUL_W-1:0]  in_b,
  output logic              mul_start,
  output logic [MUL_W-1:0]  mul_multiplicand,
  output logic [MUL_W-1:0]  mul_multiplier,
  input  logic [PROD_W-1:0] mul_product,
  input  logic              mul_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_product,
  output logic              out_zero,
  output logic              out_neg,
  output logic              out_ovf8,
  output logic              out_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  mul_disp_state_t state_q, state_d;

  logic [MUL_W-1:0]  opa_q, opa_d;
  logic [MUL_W-1:0]  opb_q, opb_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [2*MUL_W-1:0]   fifo_rdata;
  logic                 done_edge;

  assign in_ready  = ~fifo_full;
  assign fifo_push = in_valid & in_ready;
  assign fifo_pop  = (state_q == IDLE) & ~fifo_empty;

  mul_operand_fifo #(
    .DEPTH (DEPTH),
    .W     (2 * MUL_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata ({in_a, in_b}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A done level left over from the previous op must not complete this one.
  assign done_edge = mul_done & ~done_q;

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    done_d  = mul_done;
    prod_d  = prod_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          {opa_d, opb_d} = fifo_rdata;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (done_edge) begin
          prod_d  = mul_product;
          zero_d  = (mul_product == '0);
          neg_d   = mul_product[PROD_W-1];
          ovf_d   = ovf8(mul_product);
          err_d   = 1'b0;
          state_d = RESULT;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          prod_d  = '0;
          zero_d  = 1'b1;
          neg_d   = 1'b0;
          ovf_d   = 1'b0;
          err_d   = 1'b1;
          state_d = RESULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESULT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      prod_q  <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign mul_start        = (state_q == ISSUE);
  assign mul_multiplicand = opa_q;
  assign mul_multiplier   = opb_q;
  assign out_valid        = (state_q == RESULT);
  assign out_product      = prod_q;
  assign out_zero         = zero_q;
  assign out_neg          = neg_q;
  assign out_ovf8         = ovf_q;
  assign out_err          = err_q;

endmodule

// File: tb/tb_mul_dispatch.sv
// Scoreboard bench for mul_dispatch with a behavioural multiplier stub.
module tb_mul_dispatch;

  localparam int DEPTH   = 2;
  localparam int TIMEOUT = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        mul_start;
  logic [7:0]  mul_multiplicand;
  logic [7:0]  mul_multiplier;
  logic [15:0] mul_product;
  logic        mul_done;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_product;
  logic        out_zero;
  logic        out_neg;
  logic        out_ovf8;
  logic        out_err;

  mul_dispatch #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_a             (in_a),
    .in_b             (in_b),
    .mul_start        (mul_start),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_product      (mul_product),
    .mul_done         (mul_done),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_product      (out_product),
    .out_zero         (out_zero),
    .out_neg          (out_neg),
    .out_ovf8         (out_ovf8),
    .out_err          (out_err)
  );

  always #5 clk = ~clk;

  // Stub behaviours: 0 pulse, 1 complete and hold level,
  // 2 stale level then fresh edge, 3 never, 4 very late pulse.
  typedef struct {
    int mode;
    int lat;
  } op_t;

  typedef struct {
    logic [15:0] p;
    logic        z;
    logic        n;
    logic        o;
    logic        e;
    int          lat;
  } exp_t;

  op_t  mode_q[$];
  exp_t exp_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int starts = 0;
  int pushes = 0;
  int last_start = -1;
  bit stop_rnd;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic push(input int a, input int b, input int mode,
                      input int lat);
    logic [7:0] ua;
    logic [7:0] ub;
    int         pr;
    exp_t       ex;
    op_t        op;
    bit         acc;
    int         n;
    ua = a[7:0];
    ub = b[7:0];
    in_a = ua;
    in_b = ub;
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 300) begin
      @(posedge clk);
      acc = in_ready;
      #1;
      n++;
    end
    in_valid = 1'b0;
    chk("push_accept", {31'b0, acc}, 32'd1);
    if (acc) begin
      pushes++;
      pr = int'($signed(ua)) * int'($signed(ub));
      if (mode == 3) begin
        ex.p = 16'h0; ex.z = 1'b1; ex.n = 1'b0;
        ex.o = 1'b0; ex.e = 1'b1;
      end else begin
        ex.p = pr[15:0];
        ex.z = (pr == 0);
        ex.n = (pr < 0);
        ex.o = (pr > 127) || (pr < -128);
        ex.e = 1'b0;
      end
      case (mode)
        0, 1:    ex.lat = lat + 2;
        2:       ex.lat = 6;
        3:       ex.lat = TIMEOUT + 1;
        default: ex.lat = -1;
      endcase
      op.mode = mode;
      op.lat = lat;
      exp_q.push_back(ex);
      mode_q.push_back(op);
    end
  endtask

  // Multiplier stub.
  initial begin
    logic [7:0] sa;
    logic [7:0] sb;
    int         pi;
    op_t        op;
    mul_done = 1'b0;
    mul_product = 16'h0;
    forever begin
      @(posedge clk);
      if (rst_n && mul_start) begin
        sa = mul_multiplicand;
        sb = mul_multiplier;
        pi = int'($signed(sa)) * int'($signed(sb));
        if (mode_q.size() > 0) begin
          op = mode_q.pop_front();
        end else begin
          op.mode = 0;
          op.lat = 1;
        end
        case (op.mode)
          0, 1: begin
            @(negedge clk);
            mul_done = 1'b0;
            repeat (op.lat) @(negedge clk);
            mul_product = pi[15:0];
            mul_done = 1'b1;
            if (op.mode == 0) begin
              @(negedge clk);
              mul_done = 1'b0;
            end
          end
          2: begin
            @(negedge clk);
            mul_product = 16'h5A5A;
            repeat (3) @(negedge clk);
            mul_done = 1'b0;
            @(negedge clk);
            mul_product = pi[15:0];
            mul_done = 1'b1;
            @(negedge clk);
            mul_done = 1'b0;
          end
          3: begin
            @(negedge clk);
            mul_done = 1'b0;
          end
          default: begin
            @(negedge clk);
            mul_done = 1'b0;
            repeat (12) @(negedge clk);
            mul_product = pi[15:0];
            mul_done = 1'b1;
            @(negedge clk);
            mul_done = 1'b0;
          end
        endcase
      end
    end
  end

  // Monitor: start spacing, result latency and scoreboard compare.
  initial begin
    bit   prev_ov;
    exp_t ex;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
      end else begin
        if (mul_start) begin
          starts++;
          if (last_start >= 0) begin
            chk("start_gap_ge4", {31'b0, (cyc - last_start) >= 4}, 32'd1);
          end
          last_start = cyc;
        end
        if (out_valid && !prev_ov && exp_q.size() > 0 &&
            exp_q[0].lat >= 0) begin
          chk("latency", cyc - last_start, exp_q[0].lat);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got %0h want none",
                     out_product);
          end else begin
            ex = exp_q.pop_front();
            chk("result", {12'b0, out_product, out_zero, out_neg,
                           out_ovf8, out_err},
                {12'b0, ex.p, ex.z, ex.n, ex.o, ex.e});
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = 8'h0;
    in_b = 8'h0;
    out_ready = 1'b0;
    stop_rnd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_outs", {out_valid, mul_start, out_zero, out_neg,
                     out_ovf8, out_err, out_product,
                     mul_multiplicand[0], mul_multiplier[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    push(5, 3, 0, 3);
    drain();
    chk("one_start", starts, 32'd1);

    push(-4, 6, 0, $urandom_range(1, 6));
    push(50, 50, 0, $urandom_range(1, 6));
    push(-128, -128, 0, $urandom_range(1, 6));
    push(5, 0, 0, $urandom_range(1, 6));
    drain();

    out_ready = 1'b0;
    push(1, 2, 0, 2);
    push(-3, 4, 0, 2);
    push(9, -9, 0, 2);
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    fork
      push(127, 127, 0, 2);
      begin
        repeat (20) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    push(3, 4, 1, 2);
    push(-7, 9, 2, 0);
    push(2, 2, 0, 1);
    drain();

    push(11, -2, 3, 0);
    push(6, 7, 0, 2);
    drain();

    fork
      begin
        for (int i = 0; i < 30; i++) begin
          push($urandom_range(0, 255), $urandom_range(0, 255),
               ($urandom_range(0, 7) == 0) ? 1 : 0, $urandom_range(1, 6));
        end
        stop_rnd = 1'b1;
      end
      begin
        while (!stop_rnd) begin
          @(posedge clk);
          #1;
          out_ready = $urandom_range(0, 1) != 0;
        end
      end
    join
    drain();
    chk("starts_eq_pushes", starts, pushes);

    push(7, 7, 4, 0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("amid_in_ready", {31'b0, in_ready}, 32'd1);
    chk("amid_outs", {out_valid, mul_start, out_zero, out_neg,
                      out_ovf8, out_err, out_product,
                      mul_multiplicand[0], mul_multiplier[0]}, 32'd0);
    chk("amid_ops", {16'b0, mul_multiplicand, mul_multiplier}, 32'd0);
    exp_q.delete();
    mode_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid || mul_start) seen++;
    end
    chk("late_done_ignored", seen, 32'd0);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
